// File: rtl/t2mi_frame_scheduler.sv
// T2-MI per-frame packet scheduler: plp_num_blocks BB packets, optional T2 timestamp, then L1-current.
// Optional feature macro: T2MI_TIMESTAMP_EN (defined -> a timestamp packet follows the BB packets).
`timescale 1ns/1ps
module t2mi_frame_scheduler #(
  parameter logic [7:0] TYPE_BB   = 8'h00,
  parameter logic [7:0] TYPE_L1   = 8'h10,
  parameter logic [7:0] TYPE_TS   = 8'h20,
  parameter int         TIMEOUT_W = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [9:0] plp_num_blocks,
  input  logic [7:0] num_t2_frames,
  input  logic       PKT_DONE,
  output logic       PKT_REQ,
  output logic [7:0] PKT_TYPE,
  output logic [7:0] FRAME_IDX,
  output logic [3:0] SUPERFRAME_IDX,
  output logic [9:0] BLOCK_IDX,
  output logic       CFG_LATCH,
  output logic       BUSY,
  output logic       ERR_CFG,
  output logic       ERR_TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_BB,
    S_TS,
    S_L1,
    S_NEXT
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_ONE  = 1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state_q, state_d;
  logic                 req_q, req_d;
  logic [9:0]           block_q, block_d;
  logic [9:0]           cfg_blocks_q, cfg_blocks_d;
  logic [7:0]           frame_q, frame_d;
  logic [7:0]           cfg_frames_q, cfg_frames_d;
  logic [3:0]           sf_q, sf_d;
  logic                 err_cfg_q, err_cfg_d;
  logic                 err_to_q, err_to_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 wd_expire;

  // The watchdog trips on the cycle its count would become all-ones; a DONE in that cycle wins.
  assign wd_expire = req_q && !PKT_DONE && (wd_q == WD_LAST);

  // Packet states hold PKT_REQ high until DONE, then spend one low cycle in the same state
  // before either re-requesting (more BB blocks) or moving on with PKT_REQ raised on entry.
  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    block_d      = block_q;
    frame_d      = frame_q;
    sf_d         = sf_q;
    cfg_blocks_d = cfg_blocks_q;
    cfg_frames_d = cfg_frames_q;
    err_cfg_d    = err_cfg_q;
    err_to_d     = err_to_q;
    wd_d         = req_q ? wd_q + WD_ONE : '0;

    if (wd_expire) begin
      err_to_d = 1'b1;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ENABLE) state_d = S_LATCH;
        end
        S_LATCH: begin
          cfg_blocks_d = plp_num_blocks;
          cfg_frames_d = num_t2_frames;
          if (plp_num_blocks == '0 || num_t2_frames == '0) begin
            err_cfg_d = 1'b1;
            state_d   = S_IDLE;
          end else if (!ENABLE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_BB;
            req_d   = 1'b1;
          end
        end
        S_BB: begin
          if (req_q) begin
            if (PKT_DONE) begin
              block_d = block_q + 10'd1;
              req_d   = 1'b0;
              if (!ENABLE) state_d = S_IDLE;
            end
          end else if (!ENABLE) begin
            state_d = S_IDLE;
          end else if (block_q == cfg_blocks_q) begin
`ifdef T2MI_TIMESTAMP_EN
            state_d = S_TS;
`else
            state_d = S_L1;
`endif
            req_d   = 1'b1;
          end else begin
            req_d = 1'b1;
          end
        end
`ifdef T2MI_TIMESTAMP_EN
        S_TS: begin
          if (req_q) begin
            if (PKT_DONE) begin
              req_d = 1'b0;
              if (!ENABLE) state_d = S_IDLE;
            end
          end else if (!ENABLE) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_L1;
            req_d   = 1'b1;
          end
        end
`endif
        S_L1: begin
          // NEXT itself is the low cycle between the L1 request and the following one.
          if (!req_q || PKT_DONE) begin
            req_d   = 1'b0;
            state_d = ENABLE ? S_NEXT : S_IDLE;
          end
        end
        S_NEXT: begin
          block_d = '0;
          if (!ENABLE) begin
            state_d = S_IDLE;
          end else if (frame_q < cfg_frames_q - 8'd1) begin
            frame_d = frame_q + 8'd1;
            state_d = S_BB;
            req_d   = 1'b1;
          end else begin
            frame_d = '0;
            sf_d    = sf_q + 4'd1;
            state_d = S_LATCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Whatever route leads to IDLE, the request is withdrawn and the header indices restart.
    if (state_d == S_IDLE) begin
      req_d   = 1'b0;
      block_d = '0;
      frame_d = '0;
      sf_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      block_q      <= '0;
      frame_q      <= '0;
      sf_q         <= '0;
      cfg_blocks_q <= '0;
      cfg_frames_q <= '0;
      err_cfg_q    <= 1'b0;
      err_to_q     <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      block_q      <= block_d;
      frame_q      <= frame_d;
      sf_q         <= sf_d;
      cfg_blocks_q <= cfg_blocks_d;
      cfg_frames_q <= cfg_frames_d;
      err_cfg_q    <= err_cfg_d;
      err_to_q     <= err_to_d;
      wd_q         <= wd_d;
    end
  end

  // The type follows the state, which cannot change while a request is outstanding.
  always_comb begin
    PKT_TYPE = 8'h00;
    case (state_q)
      S_BB:    PKT_TYPE = TYPE_BB;
      S_TS:    PKT_TYPE = TYPE_TS;
      S_L1:    PKT_TYPE = TYPE_L1;
      default: PKT_TYPE = 8'h00;
    endcase
  end

  assign PKT_REQ        = req_q;
  assign BLOCK_IDX      = block_q;
  assign FRAME_IDX      = frame_q;
  assign SUPERFRAME_IDX = sf_q;
  assign CFG_LATCH      = (state_q == S_LATCH);
  assign BUSY           = (state_q != S_IDLE);
  assign ERR_CFG        = err_cfg_q;
  assign ERR_TIMEOUT    = err_to_q;

endmodule
